// File: rtl/coprocessor_cmd_seq.sv
// Coprocessor command sequencer: edge-triggered go from the PIO,
// add/sub/clr in one cycle, 16x16 shift-add multiply, Avalon-MM regs.
module coprocessor_cmd_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  cmd,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        busy,
  output logic        done_irq
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    MUL,
    FIN
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  state_t      state;
  state_t      state_nx;
  logic        go_q;
  logic        start;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [31:0] result;
  logic [31:0] result_nx;
  logic        carry;
  logic        carry_nx;
  logic        done;
  logic        done_nx;
  logic [1:0]  op_w;
  logic [31:0] a_w;
  logic [31:0] b_w;
  logic [31:0] b_w_nx;
  logic [31:0] acc;
  logic [31:0] acc_nx;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nx;
  logic        last;
  logic        last_nx;
  logic [32:0] sum;
  logic [32:0] diff;
  logic [31:0] term;
  logic        wr_en;

  assign start = cmd[0] & ~go_q & (state == IDLE);
  assign wr_en = chipselect & ~write_n;

  assign sum  = {1'b0, a_w} + {1'b0, b_w};
  assign diff = {1'b0, a_w} - {1'b0, b_w};
  assign term = {16'h0000, a_w[15:0]} << cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      go_q  <= 1'b0;
    end else begin
      state <= state_nx;
      go_q  <= cmd[0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opa <= '0;
      opb <= '0;
    end else if (wr_en) begin
      unique case (address)
        2'd0:    opa <= writedata;
        2'd1:    opb <= writedata;
        default: ;
      endcase
    end
  end

  // Working copies are latched at start so operand writes while busy
  // only affect the following operation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_w <= OP_ADD;
      a_w  <= '0;
    end else if (start) begin
      op_w <= cmd[2:1];
      a_w  <= opa;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      b_w    <= '0;
      acc    <= '0;
      cnt    <= '0;
      last   <= 1'b0;
      result <= '0;
      carry  <= 1'b0;
      done   <= 1'b0;
    end else begin
      b_w    <= b_w_nx;
      acc    <= acc_nx;
      cnt    <= cnt_nx;
      last   <= last_nx;
      result <= result_nx;
      carry  <= carry_nx;
      done   <= done_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    result_nx = result;
    carry_nx  = carry;
    done_nx   = done;
    b_w_nx    = b_w;
    acc_nx    = acc;
    cnt_nx    = cnt;
    last_nx   = last;
    unique case (state)
      IDLE: begin
        if (start) begin
          b_w_nx   = opb;
          acc_nx   = '0;
          cnt_nx   = '0;
          last_nx  = 1'b0;
          done_nx  = 1'b0;
          carry_nx = 1'b0;
          state_nx = (cmd[2:1] == OP_MUL) ? MUL : EXEC;
        end
      end
      EXEC: begin
        unique case (1'b1)
          (op_w == OP_ADD): begin
            result_nx = sum[31:0];
            carry_nx  = sum[32];
          end
          (op_w == OP_SUB): begin
            result_nx = diff[31:0];
            carry_nx  = diff[32];
          end
          (op_w == OP_CLR),
          (op_w == OP_MUL): begin
            result_nx = '0;
            carry_nx  = 1'b0;
          end
        endcase
        state_nx = FIN;
      end
      MUL: begin
        // Sixteen iterations, then one cycle to commit the product.
        if (last) begin
          result_nx = acc;
          carry_nx  = 1'b0;
          state_nx  = FIN;
        end else begin
          if (b_w[0]) begin
            acc_nx = acc + term;
          end
          b_w_nx = b_w >> 1;
          cnt_nx = cnt + 4'd1;
          if (cnt == 4'd15) begin
            last_nx = 1'b1;
          end
        end
      end
      FIN: begin
        done_nx  = 1'b1;
        state_nx = IDLE;
      end
    endcase
  end

  assign busy     = (state != IDLE);
  assign done_irq = done;

  always_comb begin
    readdata = '0;
    unique case (address)
      2'd0: readdata = opa;
      2'd1: readdata = opb;
      2'd2: readdata = result;
      2'd3: readdata = {29'd0, carry, done, busy};
    endcase
  end

endmodule

// File: tb/tb_coprocessor_cmd_seq.sv
// Bench for coprocessor_cmd_seq: directed edge/reset cases plus random
// operations checked against an arithmetic reference model.
module tb_coprocessor_cmd_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  cmd = 3'b000;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        busy;
  logic        done_irq;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] opa_m = '0;
  logic [31:0] opb_m = '0;

  coprocessor_cmd_seq dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd        (cmd),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .busy       (busy),
    .done_irq   (done_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    if (a == 2'd0) opa_m = d;
    if (a == 2'd1) opb_m = d;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  // Reference: {carry, result} from the arithmetic definition of each op.
  function automatic logic [32:0] model(input logic [1:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] p;
    case (op)
      2'd0: return {1'b0, a} + {1'b0, b};
      2'd1: return {(a < b), a - b};
      2'd2: begin
        p = a[15:0] * b[15:0];
        return {1'b0, p};
      end
      default: return 33'd0;
    endcase
  endfunction

  // mode 0: pulse go; 1: hold go high; 2: second rising edge while busy;
  // 3: write OPB = 3 while busy.
  task automatic run(input logic [1:0] op, input int mode,
                     input string tag);
    logic [32:0] exp;
    logic [31:0] d;
    int n;
    int lat;
    int extra;
    exp = model(op, opa_m, opb_m);
    lat = (op == 2'd2) ? 18 : 2;
    cmd = {op, 1'b1};
    tick();
    if (mode == 0 || mode == 3) cmd[0] = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (n == 1) chk({tag, "_done_clr"}, {31'd0, done_irq}, 32'd0);
      if (mode == 2 && n == 2) cmd[0] = 1'b0;
      if (mode == 2 && n == 4) cmd[0] = 1'b1;
      if (mode == 3 && n == 3) wr(2'd1, 32'd3);
      else tick();
      if (n == lat - 1) begin
        rd(2'd2, d);
        chk({tag, "_early_res"}, d, exp[31:0]);
      end
    end
    chk({tag, "_busy_cycles"}, n, lat);
    chk({tag, "_irq"}, {31'd0, done_irq}, 32'd1);
    rd(2'd2, d);
    chk({tag, "_result"}, d, exp[31:0]);
    rd(2'd3, d);
    chk({tag, "_status"}, d, {29'd0, exp[32], 2'b10});
    if (mode == 1 || mode == 2) begin
      extra = 0;
      repeat (40) begin
        tick();
        if (busy) extra++;
      end
      chk({tag, "_no_retrigger"}, extra, 0);
      rd(2'd2, d);
      chk({tag, "_res_kept"}, d, exp[31:0]);
      cmd[0] = 1'b0;
      tick();
    end
  endtask

  task automatic chk_zero(input string tag);
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      rd(i[1:0], d);
      chk($sformatf("%s_reg%0d", tag, i), d, 32'd0);
    end
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_irq"}, {31'd0, done_irq}, 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  rop;

    tick();
    tick();
    chk_zero("reset");
    reset_n = 1'b1;
    tick();

    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd1, 32'h0000_0002);
    run(2'd0, 0, "add_carry");

    wr(2'd0, 32'd5);
    wr(2'd1, 32'd9);
    run(2'd1, 0, "sub_borrow");

    wr(2'd0, 32'hABCD_1234);
    wr(2'd1, 32'h0000_FFFF);
    run(2'd2, 0, "mul");
    rd(2'd2, d);
    chk("mul_const", d, 32'h1233_EDCC);

    wr(2'd0, 32'h1234_5678);
    wr(2'd1, 32'h0000_1111);
    run(2'd0, 1, "hold_high");

    wr(2'd0, 32'h0000_00FF);
    wr(2'd1, 32'h0000_0101);
    run(2'd2, 2, "mul_reedge");

    wr(2'd0, 32'h0000_4321);
    wr(2'd1, 32'h0000_0077);
    run(2'd2, 3, "mul_opb_wr");
    rd(2'd1, d);
    chk("opb_after_wr", d, 32'd3);
    run(2'd0, 0, "add_new_opb");

    run(2'd3, 0, "clr");

    wr(2'd0, 32'h0000_BEEF);
    wr(2'd1, 32'h0000_CAFE);
    cmd = 3'b101;
    tick();
    cmd[0] = 1'b0;
    repeat (8) tick();
    chk("mid_mul_busy", {31'd0, busy}, 32'd1);
    #1;
    reset_n = 1'b0;
    opa_m = '0;
    opb_m = '0;
    chk_zero("mid_reset");
    tick();
    reset_n = 1'b1;
    tick();
    chk_zero("post_reset");
    wr(2'd0, 32'h0000_BEEF);
    wr(2'd1, 32'h0000_CAFE);
    run(2'd2, 0, "mul_after_rst");

    for (int k = 0; k < 24; k++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if (k % 6 == 1) rb = ra;
      if (k % 6 == 2) rb = 32'd0;
      if (k % 6 == 3) ra = 32'd0;
      wr(2'd0, ra);
      wr(2'd1, rb);
      rd(2'd0, d);
      chk($sformatf("rnd%0d_opa", k), d, opa_m);
      rd(2'd1, d);
      chk($sformatf("rnd%0d_opb", k), d, opb_m);
      wr(2'd2, $urandom);
      wr(2'd3, $urandom);
      run(rop, 0, $sformatf("rnd%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
